byte_group_sequencer: RTL and testbench

Upstream feeder for the 16-byte-to-32-bit pipeline word mux. It captures one 16-byte line with a valid/ready handshake. It then emits the line as four 32-bit words, group 0 to group 3, on a valid/ready output stream. It also drives the 2-bit group index that the mux uses as its select, so the mux select and the emitted word always refer to the same stored line.

---
 rtl/byte_group_sequencer.sv | 106 ++++++++++
 tb/tb_byte_group_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/byte_group_sequencer.sv
// byte_group_sequencer
// Captures one N_IN-byte line on a valid/ready input and replays it as
// NUM_GRP words of GRP bytes each, group 0 first. out_sel carries the group
// index of the word on out_data, so a downstream mux select always points
// into the same stored line as the emitted word.
//
// Handshake semantics (both streams): a transfer happens on a rising edge
// where valid and ready are both high. A source holding valid keeps its
// payload stable until the transfer. On the output side out_valid,
// out_data, out_sel and out_last come only from registers and do not depend
// on out_ready. in_ready depends combinationally on out_ready during the
// last word, so a new line can load on the same edge the last word leaves.
module byte_group_sequencer #(
  parameter int  DATA_W  = 8,
  parameter int  N_IN    = 16,
  parameter int  GRP     = 4,
  localparam int NUM_GRP = N_IN / GRP,
  localparam int SEL_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*DATA_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [GRP*DATA_W-1:0]  out_data,
  output logic [SEL_W-1:0]       out_sel,
  output logic                   out_last,
  output logic                   busy
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] LAST_G = SEL_W'(NUM_GRP - 1);

  state_t                  state_q, state_d;
  logic [SEL_W-1:0]        g_q, g_d;
  logic [N_IN*DATA_W-1:0]  buf_q;
  logic                    load;
  logic                    accept;
  logic                    xfer;
  logic                    at_last;

  // Handshake qualifiers shared by the next-state logic and in_ready.
  always_comb begin
    at_last   = (state_q == SEND) && (g_q == LAST_G);
    out_valid = (state_q == SEND);
    out_last  = at_last;
    busy      = (state_q == SEND);
    out_sel   = g_q;
    // Reset wins over any line offered in the same cycle.
    in_ready  = !rst && ((state_q == IDLE) || (at_last && out_ready));
    accept    = in_valid && in_ready;
    xfer      = out_valid && out_ready;
  end

  // Next state: an accept always restarts at group 0; otherwise a word
  // transfer advances the group or returns to IDLE after the last one.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    load    = 1'b0;
    if (accept) begin
      load    = 1'b1;
      g_d     = '0;
      state_d = SEND;
    end else if (xfer) begin
      if (at_last) begin
        g_d     = '0;
        state_d = IDLE;
      end else begin
        g_d = g_q + SEL_W'(1);
      end
    end
  end

  // State, group counter and line buffer; the buffer keeps its contents in
  // IDLE so out_data shows stale group-0 bytes until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      if (load) begin
        buf_q <= in_data;
      end
    end
  end

  // Word select: byte GRP*g lands in the MSBs, byte GRP*g+GRP-1 in the LSBs.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < GRP; k++) begin
      out_data[(GRP-1-k)*DATA_W +: DATA_W] =
        buf_q[(int'(g_q)*GRP + k)*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_byte_group_sequencer.sv
// Bench for byte_group_sequencer: a per-cycle vector table for the directed
// corner cases followed by a random-backpressure run checked against a byte
// queue filled at input accept and drained at output transfer.
module tb_byte_group_sequencer;

  localparam int DATA_W = 8;
  localparam int N_IN   = 16;
  localparam int GRP    = 4;
  localparam int SEL_W  = 2;
  localparam int LINES  = 100;
  localparam int MAX_CYC = 20000;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [N_IN*DATA_W-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [GRP*DATA_W-1:0]  out_data;
  logic [SEL_W-1:0]       out_sel;
  logic                   out_last;
  logic                   busy;

  byte_group_sequencer #(
    .DATA_W(DATA_W),
    .N_IN  (N_IN),
    .GRP   (GRP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_last (out_last),
    .busy     (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic                   rst;
    logic                   in_valid;
    logic [N_IN*DATA_W-1:0] in_data;
    logic                   out_ready;
    logic                   e_in_ready;
    logic                   e_out_valid;
    logic [31:0]            e_data;
    logic [1:0]             e_sel;
    logic                   e_last;
    logic                   e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [N_IN*DATA_W-1:0] line_of(input logic [7:0] base);
    logic [N_IN*DATA_W-1:0] l;
    l = '0;
    for (int i = 0; i < N_IN; i++) l[i*DATA_W +: DATA_W] = base + 8'(i);
    return l;
  endfunction

  function automatic void add(input logic r, input logic iv, input logic [N_IN*DATA_W-1:0] d,
                              input logic ordy, input logic eir, input logic eov,
                              input logic [31:0] edata, input logic [1:0] esel,
                              input logic elast, input logic ebusy);
    vec_t v;
    v.rst = r; v.in_valid = iv; v.in_data = d; v.out_ready = ordy;
    v.e_in_ready = eir; v.e_out_valid = eov; v.e_data = edata;
    v.e_sel = esel; v.e_last = elast; v.e_busy = ebusy;
    vecs.push_back(v);
  endfunction

  // scoreboard
  logic [DATA_W-1:0] exp_q[$];

  initial begin
    logic [N_IN*DATA_W-1:0] a, b, cur;
    logic                   have;
    logic [1:0]             exp_sel;
    logic                   prev_hold;
    logic [31:0]            prev_data;
    logic [1:0]             prev_sel;
    logic                   prev_last;
    logic [31:0]            exp_word;
    int                     lines_sent, lasts, cyc;

    a = line_of(8'h00);
    b = line_of(8'h10);

    // reset state, single line at full rate, reset beats in_valid
    add(1,1,a,1, 0,0,32'h00000000,0,0,0);
    add(0,1,a,1, 1,0,32'h00000000,0,0,0);
    add(0,0,a,1, 0,1,32'h00010203,0,0,1);
    add(0,0,a,1, 0,1,32'h04050607,1,0,1);
    add(0,0,a,1, 0,1,32'h08090A0B,2,0,1);
    add(0,0,a,1, 1,1,32'h0C0D0E0F,3,1,1);
    add(0,0,a,1, 1,0,32'h00010203,0,0,0);
    // backpressure in group 1 with a second line offered meanwhile
    add(0,1,a,1, 1,0,32'h00010203,0,0,0);
    add(0,1,b,1, 0,1,32'h00010203,0,0,1);
    add(0,1,b,0, 0,1,32'h04050607,1,0,1);
    add(0,1,b,0, 0,1,32'h04050607,1,0,1);
    add(0,1,b,0, 0,1,32'h04050607,1,0,1);
    add(0,0,b,1, 0,1,32'h04050607,1,0,1);
    add(0,0,b,1, 0,1,32'h08090A0B,2,0,1);
    add(0,0,b,1, 1,1,32'h0C0D0E0F,3,1,1);
    add(0,0,b,1, 1,0,32'h00010203,0,0,0);
    // back-to-back lines, no bubble
    add(0,1,a,1, 1,0,32'h00010203,0,0,0);
    add(0,1,b,1, 0,1,32'h00010203,0,0,1);
    add(0,1,b,1, 0,1,32'h04050607,1,0,1);
    add(0,1,b,1, 0,1,32'h08090A0B,2,0,1);
    add(0,1,b,1, 1,1,32'h0C0D0E0F,3,1,1);
    add(0,0,b,1, 0,1,32'h10111213,0,0,1);
    add(0,0,b,1, 0,1,32'h14151617,1,0,1);
    add(0,0,b,1, 0,1,32'h18191A1B,2,0,1);
    add(0,0,b,1, 1,1,32'h1C1D1E1F,3,1,1);
    add(0,0,b,1, 1,0,32'h10111213,0,0,0);
    // reset during group 2, line offered during reset is dropped
    add(0,1,a,1, 1,0,32'h10111213,0,0,0);
    add(0,0,a,1, 0,1,32'h00010203,0,0,1);
    add(0,0,a,1, 0,1,32'h04050607,1,0,1);
    add(1,1,b,1, 0,1,32'h08090A0B,2,0,1);
    add(0,0,b,1, 1,0,32'h00000000,0,0,0);
    add(0,1,b,1, 1,0,32'h00000000,0,0,0);
    add(0,0,b,1, 0,1,32'h10111213,0,0,1);
    add(0,0,b,1, 0,1,32'h14151617,1,0,1);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; in_valid = vecs[i].in_valid;
      in_data = vecs[i].in_data; out_ready = vecs[i].out_ready;
      #1;
      chk($sformatf("v%0d in_ready", i),  32'(in_ready),  32'(vecs[i].e_in_ready));
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_out_valid));
      chk($sformatf("v%0d out_data", i),  out_data,       vecs[i].e_data);
      chk($sformatf("v%0d out_sel", i),   32'(out_sel),   32'(vecs[i].e_sel));
      chk($sformatf("v%0d out_last", i),  32'(out_last),  32'(vecs[i].e_last));
      chk($sformatf("v%0d busy", i),      32'(busy),      32'(vecs[i].e_busy));
    end

    // drain the partial line left by the table
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      if (!out_valid) break;
    end
    chk("drain out_valid", 32'(out_valid), 32'd0);

    // random lines under random backpressure
    have = 1'b0; cur = '0; exp_sel = 2'd0; prev_hold = 1'b0;
    prev_data = '0; prev_sel = '0; prev_last = 1'b0;
    lines_sent = 0; lasts = 0; cyc = 0;
    while ((lines_sent < LINES || exp_q.size() > 0) && cyc < MAX_CYC) begin
      @(negedge clk);
      cyc++;
      if (!have && lines_sent < LINES && $urandom_range(0, 3) != 0) begin
        cur  = {$urandom, $urandom, $urandom, $urandom};
        have = 1'b1;
      end
      in_valid  = have;
      in_data   = have ? cur : {$urandom, $urandom, $urandom, $urandom};
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (prev_hold) begin
        chk("hold out_valid", 32'(out_valid), 32'd1);
        chk("hold out_data",  out_data,       prev_data);
        chk("hold out_sel",   32'(out_sel),   32'(prev_sel));
        chk("hold out_last",  32'(out_last),  32'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() < GRP) begin
          chk("scoreboard underflow", 32'(exp_q.size()), 32'(GRP));
        end else begin
          exp_word = '0;
          for (int k = 0; k < GRP; k++) exp_word = {exp_word[23:0], exp_q.pop_front()};
          chk("rand out_data", out_data, exp_word);
        end
        chk("rand out_sel",  32'(out_sel),  32'(exp_sel));
        chk("rand out_last", 32'(out_last), 32'(exp_sel == 2'd3));
        if (out_last) lasts++;
        exp_sel = exp_sel + 2'd1;
      end
      if (in_valid && in_ready) begin
        for (int k = 0; k < N_IN; k++) exp_q.push_back(cur[k*DATA_W +: DATA_W]);
        have = 1'b0;
        lines_sent++;
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data; prev_sel = out_sel; prev_last = out_last;
    end
    chk("rand timeout",     32'(cyc < MAX_CYC),    32'd1);
    chk("rand lines sent",  32'(lines_sent),       32'(LINES));
    chk("rand last count",  32'(lasts),            32'(LINES));
    chk("rand queue empty", 32'(exp_q.size()),     32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
